display_controller: RTL and testbench



---
 rtl/display_pkg.sv | 22 ++
 rtl/dwell_timer.sv | 27 ++
 rtl/display_controller.sv | 99 +++++++++
 tb/tb_display_controller.sv | 130 +++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the scoreboard display multiplexer.
package display_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DEFAULT_BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    SHOW_P1 = 2'd0,
    GAP_A   = 2'd1,
    SHOW_P2 = 2'd2,
    GAP_B   = 2'd3
  } disp_state_e;

  // Pass a valid BCD digit through; anything above 9 becomes the blank code.
  function automatic logic [DIGIT_W-1:0] bcd_sanitize(
    input logic [DIGIT_W-1:0] digit,
    input logic [DIGIT_W-1:0] blank = DEFAULT_BLANK_DIGIT
  );
    return (digit > DIGIT_W'(9)) ? blank : digit;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter that clears on reaching its terminal count;
// done_c_o is high for the single cycle the terminal count is held.
module dwell_timer #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] tc_i,
  output logic             done_c_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign done_c_o = (cnt_q == tc_i);

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (done_c_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_controller.sv
// Alternates two players' BCD scores onto one digit pair with fixed dwell.
// Define DISPLAY_GAP_EN to insert blank GAP_MS intervals between players.
module display_controller
  import display_pkg::*;
#(
  parameter int unsigned        HOLD_MS     = 2000,
  parameter int unsigned        GAP_MS      = 250,
  parameter logic [DIGIT_W-1:0] BLANK_DIGIT = DEFAULT_BLANK_DIGIT
) (
  input  logic               clk_1khz,
  input  logic               rst_i,
  input  logic [DIGIT_W-1:0] p1_tens_i,
  input  logic [DIGIT_W-1:0] p1_ones_i,
  input  logic [DIGIT_W-1:0] p2_tens_i,
  input  logic [DIGIT_W-1:0] p2_ones_i,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o
);

  localparam int unsigned MAX_MS = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
  localparam int unsigned CNT_W  = $clog2(MAX_MS);

  disp_state_e        state_q, state_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0]   tc_c;
  logic               done_c;

  // Terminal count depends on whether the current window is a score or a gap.
  always_comb begin
    tc_c = CNT_W'(HOLD_MS - 1);
`ifdef DISPLAY_GAP_EN
    if (state_q == GAP_A || state_q == GAP_B) tc_c = CNT_W'(GAP_MS - 1);
`endif
  end

  dwell_timer #(
    .WIDTH (CNT_W)
  ) u_dwell_timer (
    .clk_i    (clk_1khz),
    .rst_ni   (rst_i),
    .tc_i     (tc_c),
    .done_c_o (done_c)
  );

  always_comb begin
    state_d = state_q;
    if (done_c) begin
      case (state_q)
`ifdef DISPLAY_GAP_EN
        SHOW_P1: state_d = GAP_A;
        GAP_A:   state_d = SHOW_P2;
        SHOW_P2: state_d = GAP_B;
        GAP_B:   state_d = SHOW_P1;
`else
        SHOW_P1: state_d = SHOW_P2;
        SHOW_P2: state_d = SHOW_P1;
`endif
        default: state_d = SHOW_P1;
      endcase
    end
  end

  // Output word is taken from the registered state, so it trails a transition by one edge.
  always_comb begin
    tens_d = BLANK_DIGIT;
    ones_d = BLANK_DIGIT;
    case (state_q)
      SHOW_P1: begin
        tens_d = bcd_sanitize(p1_tens_i, BLANK_DIGIT);
        ones_d = bcd_sanitize(p1_ones_i, BLANK_DIGIT);
      end
      SHOW_P2: begin
        tens_d = bcd_sanitize(p2_tens_i, BLANK_DIGIT);
        ones_d = bcd_sanitize(p2_ones_i, BLANK_DIGIT);
      end
      default: begin
        tens_d = BLANK_DIGIT;
        ones_d = BLANK_DIGIT;
      end
    endcase
  end

  always_ff @(posedge clk_1khz or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= SHOW_P1;
      tens_q  <= BLANK_DIGIT;
      ones_q  <= BLANK_DIGIT;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;

endmodule

// File: tb/tb_display_controller.sv
// Directed bench for display_controller with short dwell windows.
module tb_display_controller;

  localparam int unsigned HOLD = 8;
  localparam int unsigned GAP  = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
  logic [3:0] tens, ones;

  int n_checks = 0;
  int n_fail   = 0;

  display_controller #(
    .HOLD_MS     (HOLD),
    .GAP_MS      (GAP),
    .BLANK_DIGIT (4'hF)
  ) dut (
    .clk_1khz  (clk),
    .rst_i     (rst_n),
    .p1_tens_i (p1_tens),
    .p1_ones_i (p1_ones),
    .p2_tens_i (p2_tens),
    .p2_ones_i (p2_ones),
    .tens_o    (tens),
    .ones_o    (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count consecutive edges showing the current word; returns at the first edge of the next word.
  task automatic measure(output int len, output logic [7:0] val);
    val = {tens, ones};
    len = 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if ({tens, ones} !== val) break;
      len++;
    end
  endtask

  task automatic expect_window(input string tag, input logic [7:0] exp_val, input int exp_len);
    int         len;
    logic [7:0] val;
    measure(len, val);
    check({tag, "_val"}, 32'(val), 32'(exp_val));
    check({tag, "_len"}, 32'(len), 32'(exp_len));
  endtask

  initial begin
    rst_n   = 1'b0;
    p1_tens = 4'd1; p1_ones = 4'd2;
    p2_tens = 4'd0; p2_ones = 4'd7;

    repeat (2) @(negedge clk);
    check("rst_tens", 32'(tens), 32'hF);
    check("rst_ones", 32'(ones), 32'hF);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_first_edge", 32'({tens, ones}), 32'h12);

    // Two full periods from reset release.
    for (int p = 0; p < 2; p++) begin
      expect_window("p1_win", 8'h12, HOLD);
`ifdef DISPLAY_GAP_EN
      expect_window("gap_a", 8'hFF, GAP);
`endif
      expect_window("p2_win", 8'h07, HOLD);
`ifdef DISPLAY_GAP_EN
      expect_window("gap_b", 8'hFF, GAP);
`endif
    end

    // Now at edge 0 of a P1 window; change score mid-window.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    p1_ones = 4'd3;
    @(posedge clk);
    #1;
    check("p1_change", 32'({tens, ones}), 32'h13);
    p2_ones = 4'hB;
    expect_window("p1_rest", 8'h13, HOLD - 4);
`ifdef DISPLAY_GAP_EN
    expect_window("gap_a2", 8'hFF, GAP);
`endif
    check("bad_bcd_blank", 32'({tens, ones}), 32'h0F);

    // Async reset mid-P2 window, away from any clock edge.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({tens, ones}), 32'hFF);
    p1_ones = 4'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerelease_first_edge", 32'({tens, ones}), 32'h12);
    expect_window("p1_after_rst", 8'h12, HOLD);
`ifdef DISPLAY_GAP_EN
    expect_window("gap_a3", 8'hFF, GAP);
`endif
    expect_window("p2_bad", 8'h0F, HOLD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
